prover_h_chi_addt: RTL and testbench
====================================

Name: prover_h_chi_addt

Overview:
- Shared adder tree and accumulator sitting directly downstream of the h-chi compute stage.
- Consumes tagged batches of ngates field products (mvals_out with addt_en/addt_tag) and reduces each batch to a single field element.
- Adds the result into one of two running accumulators selected by the tag.
- Exposes both sums to the sumcheck prover and returns a ready handshake that gates the upstream stage's TMUL states.

Parameters:
- ngates, 4, number of product inputs per batch; power of two, at least 2.
- nlevels, $clog2(ngates), number of reduction passes; derived, do not override. Elaboration error if ngates is not a power of two or is less than 2.

Ports:
- clk  input  1  clock.
- rstb  input  1  asynchronous reset, active-high: asserted when rstb=1.
- en  input  1  one-cycle batch-valid pulse.
- tag  input  1  accumulator select (1 = acc1, 0 = acc0); sampled with en.
- in_vals  input  F_NBITS x ngates  product batch; sampled with en.
- clear  input  1  zero both accumulators.
- ready  output  1  idle and able to accept en.
- ready_pulse  output  1  single-cycle pulse on the rising edge of ready.
- sum0  output  F_NBITS  acc0 register.
- sum1  output  F_NBITS  acc1 register.

Behaviour:
- Reset (rstb=1, async) sets:
  - state = ST_IDLE
  - acc0 = acc1 = 0
  - work regs = 0
  - level counter = 0
  - add_en_reg = 0
  - ready_dly = 1, so no ready_pulse comes out of reset.
- Reset mid-batch abandons the batch with no accumulator update.
- Outputs:
  - ready = (state==ST_IDLE) & ~en.
  - ready_pulse = ready & ~ready_dly.
- Adder bank: ngates/2 field_adder instances using the en/ready handshake.
  - Adder i sums work[2i] and work[2i+1]; results are reduced mod p by field_adder.
- ST_IDLE:
  - en=1: latch in_vals into work[], latch tag, clear level counter, set add_en_reg, go to ST_REDUCE.
  - en=0: stay.
  - clear=1: zero acc0 and acc1 this cycle.
  - clear and en in the same cycle: clear applies first; the batch then accumulates into zero, so the final sum equals the batch sum.
- ST_REDUCE:
  - Wait for ~add_en_reg and all adders ready.
  - Write adder i output to work[i]; increment the level counter.
  - If counter < nlevels: set add_en_reg and stay.
  - Otherwise: set add_en_reg and go to ST_ACC.
- ST_ACC:
  - Adder 0 inputs are muxed to (work[0], acc[tag]).
  - On completion, write acc[tag] and go to ST_IDLE.
- Ignored events:
  - en while not in ST_IDLE is ignored, with no queueing; the producer must check ready.
  - clear outside ST_IDLE is ignored.
- Latency: with a field_adder whose ready reasserts one cycle after en, ready returns 2*(nlevels+1)+1 cycles after the accepted en. For ngates=4 this is 7 cycles.
- Accumulator behaviour:
  - Unselected accumulator is unchanged.
  - Wrap-around mod p is handled by field_adder; acc never holds a value ≥ p if inputs are < p.
- sum0 and sum1 change only on the cycle after ST_ACC completion or clear.

Optional Feature:
- Macro: PROVER_H_ADDT_BATCH_CNT_EN.
- When defined:
  - Adds outputs cnt0 and cnt1, each 16 bits: the number of batches accumulated into acc0 and acc1.
  - Each counter increments on its ST_ACC completion, wraps at 2^16, is zeroed by clear and by reset.
- When undefined: no counter ports and no counter logic; behaviour is otherwise identical.

Decomposition:
- Package prover_addt_pkg holds:
  - state enum {ST_IDLE, ST_REDUCE, ST_ACC}
  - a localparam function for nlevels.
- F_NBITS stays in field_arith_defs.
- One natural sub-module: prover_h_addt_bank, the ngates/2 field_adder instances with a shared enable and an AND-reduced idle output.

Test Plan:
- Reset release, ngates=4 → ready=1, ready_pulse=0, sum0=sum1=0.
- en with tag=0, in_vals={1,2,3,4} → ready low for exactly 7 cycles, then sum0=10, sum1=0, one-cycle ready_pulse.
- Follow with tag=1 {5,5,5,5}, then tag=0 {1,1,1,1} → sum1=20, sum0=14.
- clear and en (tag=1, {7,0,0,0}) in the same cycle with prior sum0=14, sum1=20 → sum0=0, sum1=7.
- Inputs {p-1, p-1, 1, 1} with tag=0 from zero → sum0=0 (mod-p wrap); a second en pulsed while busy is ignored, so sum0 stays 0.
- Assert rstb mid-ST_REDUCE after a prior sum0=10 → sum0=0 immediately, ready=1 after release, no ready_pulse.
- With PROVER_H_ADDT_BATCH_CNT_EN: three tag=0 batches then clear → cnt0 goes 1, 2, 3, then 0.

Source files
------------

// File: rtl/field_arith_defs.sv
// Field arithmetic constants shared by the prover datapath.
// The field is the Mersenne prime 2^61-1.
package field_arith_defs;
  localparam int F_NBITS = 61;
  localparam logic [F_NBITS-1:0] F_P = {F_NBITS{1'b1}};
endpackage

// File: rtl/prover_h_chi_addt_pkg.sv
// State encoding and derived sizing for the h-chi adder tree / accumulator.
package prover_addt_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REDUCE = 2'd1,
    ST_ACC    = 2'd2
  } state_t;

  function automatic int nlevels_f(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/field_adder.sv
// Registered modular adder: result is valid the cycle after en_i, ready drops only while en_i is high.
module field_adder
  import field_arith_defs::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [F_NBITS-1:0] a_i,
  input  logic [F_NBITS-1:0] b_i,
  output logic               ready_o,
  output logic [F_NBITS-1:0] sum_o
);
  logic [F_NBITS:0]   raw;
  logic [F_NBITS:0]   wrapped;
  logic [F_NBITS-1:0] sum_q;

  assign raw     = {1'b0, a_i} + {1'b0, b_i};
  assign wrapped = raw - {1'b0, F_P};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sum_q <= '0;
    end else if (en_i) begin
      sum_q <= (raw >= {1'b0, F_P}) ? wrapped[F_NBITS-1:0] : raw[F_NBITS-1:0];
    end
  end

  assign ready_o = ~en_i;
  assign sum_o   = sum_q;
endmodule

// File: rtl/prover_h_chi_addt_bank.sv
// Bank of ngates/2 field adders sharing one enable; idle_o is high only when every adder is ready.
module prover_h_addt_bank
  import field_arith_defs::*;
#(
  parameter int NADD = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          en_i,
  input  logic [NADD-1:0][F_NBITS-1:0]  a_i,
  input  logic [NADD-1:0][F_NBITS-1:0]  b_i,
  output logic [NADD-1:0][F_NBITS-1:0]  sum_o,
  output logic                          idle_o
);
  logic [NADD-1:0] ready;

  for (genvar i = 0; i < NADD; i++) begin : g_add
    field_adder u_add (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .en_i   (en_i),
      .a_i    (a_i[i]),
      .b_i    (b_i[i]),
      .ready_o(ready[i]),
      .sum_o  (sum_o[i])
    );
  end

  assign idle_o = &ready;
endmodule

// File: rtl/prover_h_chi_addt.sv
// Shared adder tree + dual accumulator behind the h-chi stage.
// Optional per-accumulator batch counters: define PROVER_H_ADDT_BATCH_CNT_EN.
module prover_h_chi_addt
  import prover_addt_pkg::*;
  import field_arith_defs::*;
#(
  parameter int ngates = 4
) (
  input  logic                             clk,
  input  logic                             rstb,
  input  logic                             en,
  input  logic                             tag,
  input  logic [ngates-1:0][F_NBITS-1:0]   in_vals,
  input  logic                             clear,
  output logic                             ready,
  output logic                             ready_pulse,
  output logic [F_NBITS-1:0]               sum0,
  output logic [F_NBITS-1:0]               sum1
`ifdef PROVER_H_ADDT_BATCH_CNT_EN
  ,
  output logic [15:0]                      cnt0,
  output logic [15:0]                      cnt1
`endif
);
  localparam int NLEVELS = nlevels_f(ngates);
  localparam int NADD    = ngates / 2;
  localparam int CW      = $clog2(NLEVELS + 1);
  localparam logic [CW-1:0] LAST_LVL = CW'(NLEVELS - 1);

  if (ngates < 2 || (ngates & (ngates - 1)) != 0) begin : g_bad_ngates
    $error("prover_h_chi_addt: ngates must be a power of two and at least 2");
  end

  state_t                         state_q, state_d;
  logic [ngates-1:0][F_NBITS-1:0] work_q, work_d;
  logic [F_NBITS-1:0]             acc0_q, acc0_d, acc1_q, acc1_d;
  logic                           tag_q, tag_d;
  logic [CW-1:0]                  lvl_q, lvl_d;
  logic                           add_en_q, add_en_d;
  logic                           ready_dly_q;
  logic [NADD-1:0][F_NBITS-1:0]   add_a, add_b, add_sum;
  logic                           bank_idle;

  // In ST_ACC adder 0 folds the reduced batch into the selected accumulator.
  always_comb begin
    for (int i = 0; i < NADD; i++) begin
      add_a[i] = work_q[2*i];
      add_b[i] = work_q[2*i+1];
    end
    if (state_q == ST_ACC) add_b[0] = tag_q ? acc1_q : acc0_q;
  end

  prover_h_addt_bank #(.NADD(NADD)) u_bank (
    .clk_i (clk),
    .rst_i (rstb),
    .en_i  (add_en_q),
    .a_i   (add_a),
    .b_i   (add_b),
    .sum_o (add_sum),
    .idle_o(bank_idle)
  );

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    acc0_d   = acc0_q;
    acc1_d   = acc1_q;
    tag_d    = tag_q;
    lvl_d    = lvl_q;
    add_en_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          acc0_d = '0;
          acc1_d = '0;
        end
        if (en) begin
          work_d   = in_vals;
          tag_d    = tag;
          lvl_d    = '0;
          add_en_d = 1'b1;
          state_d  = ST_REDUCE;
        end
      end
      ST_REDUCE: begin
        if (!add_en_q && bank_idle) begin
          for (int i = 0; i < NADD; i++) work_d[i] = add_sum[i];
          lvl_d    = lvl_q + CW'(1);
          add_en_d = 1'b1;
          if (lvl_q == LAST_LVL) state_d = ST_ACC;
        end
      end
      ST_ACC: begin
        if (!add_en_q && bank_idle) begin
          if (tag_q) acc1_d = add_sum[0];
          else       acc0_d = add_sum[0];
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ready       = (state_q == ST_IDLE) & ~en;
  assign ready_pulse = ready & ~ready_dly_q;

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      state_q     <= ST_IDLE;
      work_q      <= '0;
      acc0_q      <= '0;
      acc1_q      <= '0;
      tag_q       <= 1'b0;
      lvl_q       <= '0;
      add_en_q    <= 1'b0;
      ready_dly_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      acc0_q      <= acc0_d;
      acc1_q      <= acc1_d;
      tag_q       <= tag_d;
      lvl_q       <= lvl_d;
      add_en_q    <= add_en_d;
      ready_dly_q <= ready;
    end
  end

  assign sum0 = acc0_q;
  assign sum1 = acc1_q;

`ifdef PROVER_H_ADDT_BATCH_CNT_EN
  logic [15:0] cnt0_q, cnt1_q;
  logic        acc_done;

  assign acc_done = (state_q == ST_ACC) && !add_en_q && bank_idle;

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (state_q == ST_IDLE && clear) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (acc_done) begin
      if (tag_q) cnt1_q <= cnt1_q + 16'd1;
      else       cnt0_q <= cnt0_q + 16'd1;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif
endmodule

// File: tb/tb_prover_h_chi_addt.sv
// Directed bench for prover_h_chi_addt with ngates=4 and hand-computed sums.
module tb_prover_h_chi_addt;
  import field_arith_defs::*;

  typedef logic [3:0][F_NBITS-1:0] batch_t;

  logic clk = 1'b0;
  logic rstb, en, tag, clear;
  batch_t in_vals;
  logic ready, ready_pulse;
  logic [F_NBITS-1:0] sum0, sum1;
`ifdef PROVER_H_ADDT_BATCH_CNT_EN
  logic [15:0] cnt0, cnt1;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  prover_h_chi_addt #(.ngates(4)) dut (
    .clk        (clk),
    .rstb       (rstb),
    .en         (en),
    .tag        (tag),
    .in_vals    (in_vals),
    .clear      (clear),
    .ready      (ready),
    .ready_pulse(ready_pulse),
    .sum0       (sum0),
    .sum1       (sum1)
`ifdef PROVER_H_ADDT_BATCH_CNT_EN
    ,
    .cnt0       (cnt0),
    .cnt1       (cnt1)
`endif
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  function automatic batch_t mk(input logic [F_NBITS-1:0] v0, input logic [F_NBITS-1:0] v1,
                                input logic [F_NBITS-1:0] v2, input logic [F_NBITS-1:0] v3);
    batch_t b;
    b[0] = v0; b[1] = v1; b[2] = v2; b[3] = v3;
    return b;
  endfunction

  // Drives one batch at a negedge and waits (bounded) for ready; optional busy-time en poke.
  task automatic run_batch(input string name, input logic t, input batch_t v, input logic clr,
                           input logic poke, input logic [63:0] exp0, input logic [63:0] exp1);
    int low;
    bit done;
    en = 1'b1; tag = t; in_vals = v; clear = clr;
    low  = 1;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (ready) begin
        done = 1'b1;
      end else begin
        en = 1'b0; clear = 1'b0;
        if (poke && low == 3) begin
          en = 1'b1; tag = 1'b0; in_vals = mk(5, 5, 5, 5);
        end
        low++;
      end
    end
    en = 1'b0; clear = 1'b0;
    chk({name, "_timeout"}, {63'd0, done}, 64'd1);
    chk({name, "_latency"}, 64'(low), 64'd7);
    chk({name, "_pulse"}, {63'd0, ready_pulse}, 64'd1);
    chk({name, "_sum0"}, {3'd0, sum0}, exp0);
    chk({name, "_sum1"}, {3'd0, sum1}, exp1);
    @(negedge clk);
    chk({name, "_pulse_off"}, {63'd0, ready_pulse}, 64'd0);
  endtask

  initial begin
    rstb = 1'b1; en = 1'b0; tag = 1'b0; clear = 1'b0; in_vals = '0;
    repeat (3) @(negedge clk);
    rstb = 1'b0;
    #1;
    chk("rst_ready", {63'd0, ready}, 64'd1);
    chk("rst_pulse", {63'd0, ready_pulse}, 64'd0);
    chk("rst_sum0", {3'd0, sum0}, 64'd0);
    chk("rst_sum1", {3'd0, sum1}, 64'd0);
    @(negedge clk);
    chk("rst_pulse2", {63'd0, ready_pulse}, 64'd0);

    run_batch("b1234", 1'b0, mk(1, 2, 3, 4), 1'b0, 1'b0, 64'd10, 64'd0);
    run_batch("b5555", 1'b1, mk(5, 5, 5, 5), 1'b0, 1'b0, 64'd10, 64'd20);
    run_batch("b1111", 1'b0, mk(1, 1, 1, 1), 1'b0, 1'b0, 64'd14, 64'd20);
    run_batch("clr_en", 1'b1, mk(7, 0, 0, 0), 1'b1, 1'b0, 64'd0, 64'd7);
    run_batch("wrap", 1'b0, mk(F_P - 1, F_P - 1, 1, 1), 1'b0, 1'b1, 64'd0, 64'd7);

    run_batch("pre_rst", 1'b0, mk(1, 2, 3, 4), 1'b0, 1'b0, 64'd10, 64'd7);
    en = 1'b1; tag = 1'b0; in_vals = mk(2, 2, 2, 2);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    rstb = 1'b1;
    #1;
    chk("midrst_sum0", {3'd0, sum0}, 64'd0);
    chk("midrst_sum1", {3'd0, sum1}, 64'd0);
    repeat (2) @(negedge clk);
    rstb = 1'b0;
    #1;
    chk("midrst_ready", {63'd0, ready}, 64'd1);
    chk("midrst_pulse", {63'd0, ready_pulse}, 64'd0);
    @(negedge clk);
    chk("midrst_pulse2", {63'd0, ready_pulse}, 64'd0);
    chk("midrst_sum0b", {3'd0, sum0}, 64'd0);

`ifdef PROVER_H_ADDT_BATCH_CNT_EN
    run_batch("c1", 1'b0, mk(1, 0, 0, 0), 1'b0, 1'b0, 64'd1, 64'd0);
    chk("cnt0_1", {48'd0, cnt0}, 64'd1);
    run_batch("c2", 1'b0, mk(1, 0, 0, 0), 1'b0, 1'b0, 64'd2, 64'd0);
    chk("cnt0_2", {48'd0, cnt0}, 64'd2);
    run_batch("c3", 1'b0, mk(1, 0, 0, 0), 1'b0, 1'b0, 64'd3, 64'd0);
    chk("cnt0_3", {48'd0, cnt0}, 64'd3);
    chk("cnt1_0", {48'd0, cnt1}, 64'd0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("cnt0_clr", {48'd0, cnt0}, 64'd0);
    chk("sum0_clr", {3'd0, sum0}, 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
